// File: rtl/reduction_pkg.sv
// Shared constants, lane types and byte-enable helper for the reduction result packer.
package reduction_pkg;

    localparam int ELEM_BITS = 64;
    localparam int BEAT_BITS = 512;
    localparam int N_ELEM    = BEAT_BITS / ELEM_BITS;
    localparam int KEEP_BITS = BEAT_BITS / 8;
    localparam int LANE_W    = $clog2(N_ELEM);
    localparam int CNT_W     = LANE_W + 1;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Byte enables for a beat whose low `count` lanes carry data.
    function automatic logic [KEEP_BITS-1:0] keep_mask(input cnt_t count);
        logic [KEEP_BITS-1:0] mask;
        mask = '0;
        for (int i = 0; i < KEEP_BITS; i++) begin
            if (i < int'(count) * (ELEM_BITS / 8)) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/reduction_pack_oreg.sv
// Single-entry AXI4-Stream output register: loads a closed beat, holds it until accepted downstream.
module reduction_pack_oreg #(
    parameter int DATA_BITS = 512
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [DATA_BITS-1:0]   load_data,
    input  logic [DATA_BITS/8-1:0] load_keep,
    input  logic                   load_last,
    input  logic                   tready,
    output logic                   tvalid,
    output logic [DATA_BITS-1:0]   tdata,
    output logic [DATA_BITS/8-1:0] tkeep,
    output logic                   tlast,
    output logic                   free
);

    // The slot can take a new beat when empty or when its current beat leaves this cycle.
    assign free = ~tvalid | tready;

    // Beat storage; a load in the same cycle as a drain simply replaces the contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tkeep  <= '0;
            tlast  <= 1'b0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= load_data;
            tkeep  <= load_keep;
            tlast  <= load_last;
        end else if (tvalid & tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/reduction_result_packer.sv
// Packs 64-bit reduction results into 512-bit AXI4-Stream beats, closing on a full beat or last.
module reduction_result_packer #(
    parameter int DATA_BITS = 512,
    parameter int ELEM_BITS = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ELEM_BITS-1:0]   in_data,
    input  logic                   in_last,
    output logic                   out_tvalid,
    input  logic                   out_tready,
    output logic [DATA_BITS-1:0]   out_tdata,
    output logic [DATA_BITS/8-1:0] out_tkeep,
    output logic                   out_tlast,
    output logic [31:0]            stat_beats,
    output logic [31:0]            stat_elems
);
    import reduction_pkg::*;

    // The lane types and keep helper are sized from the package widths.
    if (DATA_BITS != BEAT_BITS || ELEM_BITS != reduction_pkg::ELEM_BITS) begin : g_param_check
        $error("reduction_result_packer widths must match reduction_pkg");
    end

    lane_t                   acc_cnt_r;
    logic [DATA_BITS-1:0]    acc_data_r;
    logic [31:0]             stat_beats_r;
    logic [31:0]             stat_elems_r;
    logic                    free_s;
    logic                    accept_s;
    logic                    close_s;
    logic                    drain_s;
    logic [DATA_BITS-1:0]    beat_data_s;
    logic [DATA_BITS/8-1:0]  beat_keep_s;

    assign in_ready   = ~reset & free_s;
    assign accept_s   = in_valid & in_ready;
    assign close_s    = accept_s & ((acc_cnt_r == lane_t'(N_ELEM - 1)) | in_last);
    assign drain_s    = out_tvalid & out_tready;
    assign stat_beats = stat_beats_r;
    assign stat_elems = stat_elems_r;

    // Accumulator contents with the incoming element dropped into lane acc_cnt.
    always_comb begin
        beat_data_s = acc_data_r;
        for (int k = 0; k < N_ELEM; k++) begin
            if (acc_cnt_r == lane_t'(k)) begin
                beat_data_s[k*ELEM_BITS +: ELEM_BITS] = in_data;
            end else begin
                beat_data_s[k*ELEM_BITS +: ELEM_BITS] = acc_data_r[k*ELEM_BITS +: ELEM_BITS];
            end
        end
        beat_keep_s = keep_mask(cnt_t'(acc_cnt_r) + cnt_t'(1));
    end

    // Lanes not yet written stay zero because the accumulator clears on every close.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_cnt_r  <= '0;
            acc_data_r <= '0;
        end else if (close_s) begin
            acc_cnt_r  <= '0;
            acc_data_r <= '0;
        end else if (accept_s) begin
            acc_cnt_r  <= acc_cnt_r + lane_t'(1);
            acc_data_r <= beat_data_s;
        end
    end

    // Handshake counters, wrapping at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_beats_r <= 32'd0;
            stat_elems_r <= 32'd0;
        end else begin
            if (drain_s) begin
                stat_beats_r <= stat_beats_r + 32'd1;
            end
            if (accept_s) begin
                stat_elems_r <= stat_elems_r + 32'd1;
            end
        end
    end

    reduction_pack_oreg #(
        .DATA_BITS (DATA_BITS)
    ) u_oreg (
        .clock     (clock),
        .reset     (reset),
        .load      (close_s),
        .load_data (beat_data_s),
        .load_keep (beat_keep_s),
        .load_last (in_last),
        .tready    (out_tready),
        .tvalid    (out_tvalid),
        .tdata     (out_tdata),
        .tkeep     (out_tkeep),
        .tlast     (out_tlast),
        .free      (free_s)
    );

endmodule

// File: tb/tb_reduction_result_packer.sv
// Directed and randomized bench for reduction_result_packer with a queue-based beat model.
module tb_reduction_result_packer;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;
    logic         out_tvalid;
    logic         out_tready;
    logic [511:0] out_tdata;
    logic [63:0]  out_tkeep;
    logic         out_tlast;
    logic [31:0]  stat_beats;
    logic [31:0]  stat_elems;

    int tests = 0;
    int fails = 0;

    logic [63:0]  acc_q[$];
    logic [511:0] exp_data_q[$];
    logic [63:0]  exp_keep_q[$];
    logic         exp_last_q[$];
    logic [31:0]  elems_m;
    logic [31:0]  beats_m;
    logic         rnd_ready;
    logic         hold_v = 1'b0;
    logic [511:0] hold_data;
    logic [63:0]  hold_keep;
    logic         hold_last;

    reduction_result_packer dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tkeep  (out_tkeep),
        .out_tlast  (out_tlast),
        .stat_beats (stat_beats),
        .stat_elems (stat_elems)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: collect accepted elements, emit a beat on 8 elements or last.
    always @(negedge clock) begin
        if (reset) begin
            acc_q.delete();
            exp_data_q.delete();
            exp_keep_q.delete();
            exp_last_q.delete();
            elems_m = 32'd0;
            beats_m = 32'd0;
            hold_v  = 1'b0;
        end else begin
            chk("in_ready_rule", 512'(in_ready), 512'(!out_tvalid || out_tready));
            if (hold_v) begin
                chk("hold_valid", 512'(out_tvalid), 512'(1'b1));
                chk("hold_data", out_tdata, hold_data);
                chk("hold_keep", 512'(out_tkeep), 512'(hold_keep));
                chk("hold_last", 512'(out_tlast), 512'(hold_last));
            end
            if (out_tvalid && out_tready) begin
                chk("beat_expected", 512'(exp_data_q.size() > 0), 512'(1'b1));
                if (exp_data_q.size() > 0) begin
                    chk("beat_data", out_tdata, exp_data_q.pop_front());
                    chk("beat_keep", 512'(out_tkeep), 512'(exp_keep_q.pop_front()));
                    chk("beat_last", 512'(out_tlast), 512'(exp_last_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                acc_q.push_back(in_data);
                elems_m = elems_m + 32'd1;
                if (in_last || acc_q.size() == 8) begin
                    logic [511:0] d;
                    logic [63:0]  k;
                    int           n;
                    n = acc_q.size();
                    d = '0;
                    for (int i = 0; i < n; i++) d[i*64 +: 64] = acc_q[i];
                    k = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (n * 8)) - 64'd1);
                    exp_data_q.push_back(d);
                    exp_keep_q.push_back(k);
                    exp_last_q.push_back(in_last);
                    beats_m = beats_m + 32'd1;
                    acc_q.delete();
                end
            end
            hold_v    = out_tvalid && !out_tready;
            hold_data = out_tdata;
            hold_keep = out_tkeep;
            hold_last = out_tlast;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rnd_ready) out_tready = ($urandom_range(3, 0) != 0);
    endtask

    task automatic send(input logic [63:0] d, input logic l, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!acc && waits < 200) begin
            @(negedge clock);
            acc = in_ready;
            tick();
            waits++;
        end
        chk("send_accept", 512'(acc), 512'(1'b1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        rnd_ready  = 1'b0;
        out_tready = 1'b1;
        in_valid   = 1'b0;
        n = 0;
        while ((exp_data_q.size() != 0 || out_tvalid) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_pending", 512'(exp_data_q.size()), 512'(0));
        chk("drain_tvalid", 512'(out_tvalid), 512'(1'b0));
        chk("stat_beats_model", 512'(stat_beats), 512'(beats_m));
        chk("stat_elems_model", 512'(stat_elems), 512'(elems_m));
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("rst_in_ready", 512'(in_ready), 512'(1'b0));
        chk("rst_tvalid", 512'(out_tvalid), 512'(1'b0));
        chk("rst_tdata", out_tdata, 512'(0));
        chk("rst_tkeep", 512'(out_tkeep), 512'(0));
        chk("rst_tlast", 512'(out_tlast), 512'(1'b0));
        chk("rst_stat_beats", 512'(stat_beats), 512'(0));
        chk("rst_stat_elems", 512'(stat_elems), 512'(0));
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [511:0] exp_d;
        logic [63:0]  rd;
        int           w;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = 64'd0;
        in_last    = 1'b0;
        out_tready = 1'b0;
        rnd_ready  = 1'b0;
        do_reset();

        // Full beat 1..8 with last on the 8th
        out_tready = 1'b1;
        exp_d = '0;
        for (int i = 1; i <= 8; i++) begin
            send(64'(i), (i == 8), w);
            exp_d[(i-1)*64 +: 64] = 64'(i);
        end
        chk("full_tvalid", 512'(out_tvalid), 512'(1'b1));
        chk("full_tdata", out_tdata, exp_d);
        chk("full_tkeep", 512'(out_tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("full_tlast", 512'(out_tlast), 512'(1'b1));
        drain();
        chk("full_stat_beats", 512'(stat_beats), 512'(32'd1));
        chk("full_stat_elems", 512'(stat_elems), 512'(32'd8));

        // Partial beat A,B,C closed by last
        send(64'hA, 1'b0, w);
        send(64'hB, 1'b0, w);
        send(64'hC, 1'b1, w);
        exp_d = '0;
        exp_d[63:0]    = 64'hA;
        exp_d[127:64]  = 64'hB;
        exp_d[191:128] = 64'hC;
        chk("part_tdata", out_tdata, exp_d);
        chk("part_tkeep", 512'(out_tkeep), 512'(64'h0000_0000_00FF_FFFF));
        chk("part_tlast", 512'(out_tlast), 512'(1'b1));
        drain();

        // 20 back-to-back elements: two full beats then a 4-lane last beat
        for (int i = 1; i <= 20; i++) begin
            send({$urandom, $urandom}, (i == 20), w);
            chk("b2b_wait", 512'(w), 512'(1));
            if (i == 8 || i == 16) chk("b2b_mid_tlast", 512'(out_tlast), 512'(1'b0));
        end
        chk("b2b_tkeep", 512'(out_tkeep), 512'(64'h0000_0000_FFFF_FFFF));
        chk("b2b_tlast", 512'(out_tlast), 512'(1'b1));
        drain();

        // Backpressure: first beat held, input stalls, nothing lost after release
        do_reset();
        out_tready = 1'b0;
        for (int i = 1; i <= 8; i++) send(64'(100 + i), 1'b0, w);
        chk("bp_tvalid", 512'(out_tvalid), 512'(1'b1));
        chk("bp_in_ready", 512'(in_ready), 512'(1'b0));
        in_valid = 1'b1;
        in_data  = 64'd109;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_stall_ready", 512'(in_ready), 512'(1'b0));
        end
        out_tready = 1'b1;
        for (int i = 9; i <= 16; i++) send(64'(100 + i), (i == 16), w);
        drain();
        chk("bp_stat_elems", 512'(stat_elems), 512'(32'd16));
        chk("bp_stat_beats", 512'(stat_beats), 512'(32'd2));

        // Reset mid-accumulation discards the partial data
        for (int i = 1; i <= 5; i++) send(64'(200 + i), 1'b0, w);
        do_reset();
        out_tready = 1'b1;
        rd = {$urandom, $urandom};
        send(rd, 1'b1, w);
        chk("mid_rst_lane0", 512'(out_tdata[63:0]), 512'(rd));
        chk("mid_rst_tkeep", 512'(out_tkeep), 512'(64'h0000_0000_0000_00FF));
        drain();
        chk("mid_rst_elems", 512'(stat_elems), 512'(32'd1));
        chk("mid_rst_beats", 512'(stat_beats), 512'(32'd1));

        // Beat counter wrap
        force dut.stat_beats_r = 32'hFFFF_FFFF;
        #1;
        release dut.stat_beats_r;
        beats_m = 32'hFFFF_FFFF;
        send(64'h5A5A, 1'b1, w);
        drain();
        chk("wrap_stat_beats", 512'(stat_beats), 512'(32'd0));

        // Randomized traffic with random gaps and backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(3, 1)) tick();
            end
            send({$urandom, $urandom}, (i == 399) || ($urandom_range(5, 0) == 0), w);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
